// File: rtl/condicionador_botoes.sv
// Input conditioner for the seven game buttons. It synchronizes, debounces and validates the raw button vector.
// It produces a clean one-hot press code plus single-cycle press, release and chord events.
module condicionador_botoes #(
   parameter int DEBOUNCE_CYCLES = 20
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       enable,
   input  logic [6:0] botoes_raw,
   output logic [6:0] botoes,
   output logic       jogada,
   output logic       soltou,
   output logic       invalido,
   output logic [2:0] db_estado
);

   typedef enum logic [2:0] {
      OCIOSO      = 3'b000,
      PRESSIONADO = 3'b001,
      SOLTO       = 3'b010,
      INVALIDO    = 3'b011,
      BLOQUEADO   = 3'b100
   } estado_t;

   localparam logic [9:0] CNT_LAST = 10'(DEBOUNCE_CYCLES - 1);

   logic [6:0] s1_q, s2_q;
   logic [6:0] cand_q, cand_d;
   logic [6:0] deb_q, deb_d;
   logic [9:0] cnt_q, cnt_d;

   estado_t    estado_q;
   logic [6:0] botoes_q;
   logic       jogada_q, soltou_q, invalido_q;

   logic       debZero, debChord;

   // Any change of the synchronized value restarts the stability count from scratch.
   always_comb begin
      cand_d = cand_q;
      deb_d  = deb_q;
      cnt_d  = '0;
      if (s2_q != cand_q) begin
         cand_d = s2_q;
      end else if (cand_q != deb_q) begin
         if (cnt_q == CNT_LAST) begin
            deb_d = cand_q;
         end else begin
            cnt_d = cnt_q + 10'd1;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         s1_q   <= '0;
         s2_q   <= '0;
         cand_q <= '0;
         deb_q  <= '0;
         cnt_q  <= '0;
      end else begin
         s1_q   <= botoes_raw;
         s2_q   <= s1_q;
         cand_q <= cand_d;
         deb_q  <= deb_d;
         cnt_q  <= cnt_d;
      end
   end

   assign debZero  = (deb_q == 7'd0);
   assign debChord = !debZero && ((deb_q & (deb_q - 7'd1)) != 7'd0);

   // A low enable overrides every other transition in every state.
   always_ff @(posedge clock) begin
      if (!reset) begin
         estado_q   <= OCIOSO;
         botoes_q   <= '0;
         jogada_q   <= 1'b0;
         soltou_q   <= 1'b0;
         invalido_q <= 1'b0;
      end else begin
         jogada_q   <= 1'b0;
         soltou_q   <= 1'b0;
         invalido_q <= 1'b0;
         case (estado_q)
            OCIOSO: begin
               if (!enable) begin
                  estado_q <= BLOQUEADO;
               end else if (debChord) begin
                  estado_q   <= INVALIDO;
                  invalido_q <= 1'b1;
               end else if (!debZero) begin
                  estado_q <= PRESSIONADO;
                  botoes_q <= deb_q;
                  jogada_q <= 1'b1;
               end
            end
            PRESSIONADO: begin
               if (!enable) begin
                  estado_q <= BLOQUEADO;
                  botoes_q <= '0;
               end else if (debZero) begin
                  estado_q <= SOLTO;
                  soltou_q <= 1'b1;
                  botoes_q <= '0;
               end else if (deb_q != botoes_q) begin
                  estado_q   <= INVALIDO;
                  invalido_q <= 1'b1;
                  botoes_q   <= '0;
               end
            end
            SOLTO: begin
               estado_q <= enable ? OCIOSO : BLOQUEADO;
            end
            INVALIDO: begin
               if (!enable) begin
                  estado_q <= BLOQUEADO;
               end else if (debZero) begin
                  estado_q <= OCIOSO;
               end
            end
            BLOQUEADO: begin
               // A button held while enable rises must be released before it can count.
               if (enable && debZero) begin
                  estado_q <= OCIOSO;
               end
            end
            default: begin
               estado_q <= OCIOSO;
               botoes_q <= '0;
            end
         endcase
      end
   end

   assign botoes    = botoes_q;
   assign jogada    = jogada_q;
   assign soltou    = soltou_q;
   assign invalido  = invalido_q;
   assign db_estado = estado_q;

endmodule

// File: tb/tb_condicionador_botoes.sv
// Self-checking bench for condicionador_botoes: an abstract model is compared every cycle.
// Literal latency checks from the directed scenarios pin that model.
module tb_condicionador_botoes;

   localparam int D = 4;

   localparam logic [2:0] M_OCIOSO = 3'b000;
   localparam logic [2:0] M_PRESS  = 3'b001;
   localparam logic [2:0] M_SOLTO  = 3'b010;
   localparam logic [2:0] M_INV    = 3'b011;
   localparam logic [2:0] M_BLOQ   = 3'b100;

   logic       clock;
   logic       reset;
   logic       enable;
   logic [6:0] botoes_raw;
   logic [6:0] botoes;
   logic       jogada, soltou, invalido;
   logic [2:0] db_estado;

   int tests  = 0;
   int errors = 0;

   condicionador_botoes #(.DEBOUNCE_CYCLES(D)) dut (
      .clock      (clock),
      .reset      (reset),
      .enable     (enable),
      .botoes_raw (botoes_raw),
      .botoes     (botoes),
      .jogada     (jogada),
      .soltou     (soltou),
      .invalido   (invalido),
      .db_estado  (db_estado)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Model state: a two-edge delay, a stable-run length and the accepted state.
   bit         modelValid = 0;
   logic [6:0] s1m, s2m, lastS2, debM, botM;
   int         runLen;
   logic [2:0] stM;
   logic       jogM, soltM, invM;

   always @(posedge clock) begin
      if (!reset) begin
         s1m = '0; s2m = '0; lastS2 = '0; debM = '0; runLen = 0;
         stM = M_OCIOSO; botM = '0; jogM = 0; soltM = 0; invM = 0;
         modelValid = 1;
      end else if (modelValid) begin
         jogM = 0; soltM = 0; invM = 0;
         case (stM)
            M_OCIOSO:
               if (!enable) stM = M_BLOQ;
               else if ($countones(debM) >= 2) begin stM = M_INV; invM = 1; end
               else if ($countones(debM) == 1) begin stM = M_PRESS; botM = debM; jogM = 1; end
            M_PRESS:
               if (!enable) begin stM = M_BLOQ; botM = '0; end
               else if (debM == 0) begin stM = M_SOLTO; soltM = 1; botM = '0; end
               else if (debM != botM) begin stM = M_INV; invM = 1; botM = '0; end
            M_SOLTO:
               stM = enable ? M_OCIOSO : M_BLOQ;
            M_INV:
               if (!enable) stM = M_BLOQ;
               else if (debM == 0) stM = M_OCIOSO;
            default:
               if (enable && debM == 0) stM = M_OCIOSO;
         endcase
         // A value is accepted once D+1 consecutive synchronized samples agree on it.
         if (s2m == lastS2) runLen++;
         else begin lastS2 = s2m; runLen = 1; end
         if (runLen >= D + 1 && debM != s2m) debM = s2m;
         s2m = s1m;
         s1m = botoes_raw;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
      end
   endtask

   always @(negedge clock) begin
      if (modelValid) begin
         checkOutput("model botoes",    32'(botoes),    32'(botM));
         checkOutput("model jogada",    32'(jogada),    32'(jogM));
         checkOutput("model soltou",    32'(soltou),    32'(soltM));
         checkOutput("model invalido",  32'(invalido),  32'(invM));
         checkOutput("model db_estado", 32'(db_estado), 32'(stM));
      end
   end

   task automatic applyStimulus(input logic [6:0] raw, input logic en, input logic rst);
      botoes_raw = raw;
      enable     = en;
      reset      = rst;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      applyStimulus(7'b0, 1'b1, 1'b0);
      waitEdges(2);

      // Reset / idle
      applyStimulus(7'b0, 1'b1, 1'b1);
      waitEdges(20);
      checkOutput("idle botoes", 32'(botoes), 32'h0);
      checkOutput("idle estado", 32'(db_estado), 32'h0);

      // Clean press
      applyStimulus(7'b0000100, 1'b1, 1'b1);
      waitEdges(7);
      checkOutput("press jogada early", 32'(jogada), 32'h0);
      waitEdges(1);
      checkOutput("press jogada", 32'(jogada), 32'h1);
      checkOutput("press botoes", 32'(botoes), 32'h04);
      checkOutput("press estado", 32'(db_estado), 32'h1);
      waitEdges(1);
      checkOutput("press jogada width", 32'(jogada), 32'h0);
      waitEdges(6);
      applyStimulus(7'b0, 1'b1, 1'b1);
      waitEdges(7);
      checkOutput("release botoes held", 32'(botoes), 32'h04);
      waitEdges(1);
      checkOutput("release soltou", 32'(soltou), 32'h1);
      checkOutput("release botoes", 32'(botoes), 32'h0);
      checkOutput("release estado solto", 32'(db_estado), 32'h2);
      waitEdges(1);
      checkOutput("release estado ocioso", 32'(db_estado), 32'h0);
      waitEdges(3);

      // Bounce
      for (int i = 0; i < 6; i++) begin
         applyStimulus((i % 2 == 0) ? 7'b0000001 : 7'b0, 1'b1, 1'b1);
         waitEdges(2);
      end
      applyStimulus(7'b0000001, 1'b1, 1'b1);
      waitEdges(7);
      checkOutput("bounce jogada early", 32'(jogada), 32'h0);
      waitEdges(1);
      checkOutput("bounce jogada", 32'(jogada), 32'h1);
      checkOutput("bounce botoes", 32'(botoes), 32'h01);
      waitEdges(4);
      applyStimulus(7'b0, 1'b1, 1'b1);
      waitEdges(12);

      // Chord
      applyStimulus(7'b0000011, 1'b1, 1'b1);
      waitEdges(8);
      checkOutput("chord invalido", 32'(invalido), 32'h1);
      checkOutput("chord botoes", 32'(botoes), 32'h0);
      checkOutput("chord estado", 32'(db_estado), 32'h3);
      waitEdges(2);
      applyStimulus(7'b0, 1'b1, 1'b1);
      waitEdges(10);
      checkOutput("chord back ocioso", 32'(db_estado), 32'h0);

      // Slide
      applyStimulus(7'b0000001, 1'b1, 1'b1);
      waitEdges(8);
      checkOutput("slide jogada", 32'(jogada), 32'h1);
      waitEdges(2);
      applyStimulus(7'b0000010, 1'b1, 1'b1);
      waitEdges(8);
      checkOutput("slide invalido", 32'(invalido), 32'h1);
      checkOutput("slide botoes", 32'(botoes), 32'h0);
      waitEdges(4);
      applyStimulus(7'b0, 1'b1, 1'b1);
      waitEdges(10);
      checkOutput("slide back ocioso", 32'(db_estado), 32'h0);

      // Blocking
      applyStimulus(7'b0, 1'b0, 1'b1);
      waitEdges(2);
      checkOutput("block estado", 32'(db_estado), 32'h4);
      applyStimulus(7'b0001000, 1'b0, 1'b1);
      waitEdges(10);
      applyStimulus(7'b0001000, 1'b1, 1'b1);
      waitEdges(10);
      checkOutput("block held estado", 32'(db_estado), 32'h4);
      checkOutput("block held botoes", 32'(botoes), 32'h0);
      applyStimulus(7'b0, 1'b1, 1'b1);
      waitEdges(10);
      checkOutput("block released", 32'(db_estado), 32'h0);
      applyStimulus(7'b0001000, 1'b1, 1'b1);
      waitEdges(8);
      checkOutput("block repress jogada", 32'(jogada), 32'h1);
      checkOutput("block repress botoes", 32'(botoes), 32'h08);
      waitEdges(2);
      applyStimulus(7'b0001000, 1'b1, 1'b0);
      waitEdges(1);
      checkOutput("midpress reset botoes", 32'(botoes), 32'h0);
      checkOutput("midpress reset estado", 32'(db_estado), 32'h0);
      applyStimulus(7'b0001000, 1'b1, 1'b1);
      waitEdges(8);
      checkOutput("post reset accept", 32'(jogada), 32'h1);
      waitEdges(3);

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

// File: doc/condicionador_botoes.md
# condicionador_botoes

Input conditioner for the seven game buttons: synchronizes, debounces and validates the raw push-button vector and delivers a clean one-hot `botoes` vector plus single-cycle press/release events. Sits directly upstream of `circuito_S1`. Its `botoes` output drives the circuit's `botoes` input, so each physical press appears as exactly one stable one-hot code. Bounces, chords and presses made while input is blocked are filtered out.

## Interface
- `DEBOUNCE_CYCLES`, default 20: consecutive stable cycles required before a synchronized change is accepted (20 ms at 1 kHz); legal range 2..1023.
- `clock`  in  1  system clock, rising-edge active.
- `reset`  in  1  synchronous, active-low (0 = reset); sampled on `clock` rising edge.
- `enable`  in  1  1 = presses accepted; 0 = input blocked.
- `botoes_raw`  in  7  raw, asynchronous, bouncing button levels (1 = pressed).
- `botoes`  out  7  clean one-hot code of the accepted button; held while pressed, else 0.
- `jogada`  out  1  one-cycle pulse when a valid press is accepted.
- `soltou`  out  1  one-cycle pulse when an accepted button is released.
- `invalido`  out  1  one-cycle pulse when a chord (≥2 buttons) is detected.
- `db_estado`  out  3  current FSM state code.

## Operation
- Synchronizer: two-flop chain per bit, `botoes_raw` → `s1` → `s2`.
- Debouncer: register `cand` (7 b), counter `cnt` (10 b), register `deb` (7 b).
  - If `s2 != cand`: `cand <= s2`, `cnt <= 0`.
  - Else if `cand != deb`: `cnt <= cnt+1`. When `cnt == DEBOUNCE_CYCLES-1`: `deb <= cand`, `cnt <= 0`.
  - Else: `cnt` holds 0.
- FSM, registered outputs, codes in `db_estado`:
  - OCIOSO 000.
    - `enable=0` → BLOQUEADO.
    - `deb` one-hot → PRESSIONADO: `botoes <= deb`, `jogada` pulse.
    - `deb` has ≥2 bits → INVALIDO: `invalido` pulse.
  - PRESSIONADO 001: `botoes` held.
    - `deb==0` → SOLTO: `soltou` pulse, `botoes <= 0`.
    - `deb` nonzero and `!= botoes` → INVALIDO: `invalido` pulse, `botoes <= 0`.
    - `enable=0` → BLOQUEADO: `botoes <= 0`, no `soltou`.
  - SOLTO 010: one cycle, then → OCIOSO.
  - INVALIDO 011: `botoes=0`. Stays until `deb==0`, then → OCIOSO, or → BLOQUEADO if `enable=0`.
  - BLOQUEADO 100: `botoes=0`. Exits to OCIOSO only when `enable=1` and `deb==0`. A button held across enable rising is never accepted; it must be released first.
- Priority within a state: `enable=0` over every other condition.
- Chord check: `deb != 0 && (deb & (deb-1)) != 0`.

## Timing
- Reset (`reset=0` at a rising edge): `s1`, `s2`, `cand`, `deb`, `cnt` ← 0; FSM ← OCIOSO; all outputs ← 0 (`botoes=0`, `jogada=soltou=invalido=0`, `db_estado=000`).
  - Reset wins over every other input, including mid-press and mid-debounce.
  - After reset release, a button still held is accepted after the normal latency.
- Latency: `botoes_raw` changes before edge k and then holds.
  - `s2` changes at edge k+1.
  - `cand` matches at edge k+2.
  - `deb` updates at edge k+2+DEBOUNCE_CYCLES.
  - `botoes`/`jogada`/`soltou`/`invalido` assert after edge k+3+DEBOUNCE_CYCLES, i.e. `DEBOUNCE_CYCLES+3` cycles total.
- Any `s2` change before the count completes restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `deb`.
- `jogada`, `soltou`, `invalido` are exactly one cycle wide and mutually exclusive.
- `botoes` changes only on the same edge as `jogada`, `soltou`, `invalido` or entry to BLOQUEADO.
- Minimum press-to-press spacing: press debounce + release debounce + SOLTO cycle.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- Reset/idle: hold `reset=0` for 2 cycles, then `reset=1` with `botoes_raw=0`, `enable=1` → all outputs 0, `db_estado=000` for 20 cycles.
- Clean press: `botoes_raw=0000100` held 15 cycles, then 0 →
  - `jogada` high exactly 1 cycle, 7 cycles after the raw edge; `botoes=0000100` from that cycle.
  - `soltou` 1-cycle pulse 7 cycles after release, with `botoes=0` on the same edge; `db_estado` passes through 001, 010, 000.
- Bounce: toggle bit 0 every 2 cycles for 12 cycles, then hold 1 → exactly one `jogada`, 7 cycles after the final edge; `botoes=0000001`.
- Chord: `botoes_raw=0000011` held 10 cycles → `invalido` pulse, `botoes` stays 0, no `jogada`; after release returns to OCIOSO with no `soltou`.
- Slide: press `0000001`, accepted; switch directly to `0000010` → `invalido` pulse, `botoes=0`, no second `jogada` until full release and a new press.
- Blocking: hold `0001000` while `enable=0`, raise `enable` while still held → no `jogada`, `db_estado=100`. Release, then press `0001000` again → accepted normally. Assert `reset=0` mid-press → outputs 0 on the next edge.
